// File: rtl/mmio_input_bank.sv
// -----------------------------------------------------------------------------
// mmio_input_bank
//
// Memory-mapped input controller for IN_WIDTH switch/key lines. Each line is
// debounced independently. Every accepted level change on a line that is
// enabled in MASK latches an EDGE bit and raises the ready flag. A second
// change that arrives while ready is still set raises overrun. irq is
// IE & ready.
//
// Register map (byte offsets from BASE):
//   +0  DATA  RO   debounced levels, zero-extended
//   +4  CTRL       bit0 ready (RO, cleared by a DATA read)
//                  bit2 overrun (writing 0 clears it)
//                  bit8 IE (RW)
//   +8  MASK  RW   change-enable per line
//   +12 EDGE  W1C  latched change per line
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   we, re      bus write / read strobes
//   memAddr     bus byte address
//   dataBusIn   write data
//   in          raw switch/key levels
//   dataBusOut  read data, zero when the device is not selected
//   irq         interrupt request
//
// Build option:
//   INPUT_SYNC_EN  when defined, a two-flop synchroniser per line sits in front
//                  of the debounce sampler. This adds 2 cycles of latency.
// -----------------------------------------------------------------------------
module mmio_input_bank #(
  parameter int                    IN_WIDTH      = 10,
  parameter int                    BITS          = 32,
  parameter logic [BITS-1:0]       BASE          = 32'hF0000010,
  parameter int                    DEBOUNCE_TIME = 250000,
  parameter logic [IN_WIDTH-1:0]   MASK_RESET    = '1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic                re,
  input  logic [BITS-1:0]     memAddr,
  input  logic [BITS-1:0]     dataBusIn,
  input  logic [IN_WIDTH-1:0] in,
  output logic [BITS-1:0]     dataBusOut,
  output logic                irq
);

  localparam int              CNT_W     = $clog2(DEBOUNCE_TIME + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_TIME);

  localparam logic [BITS-1:0] ADDR_DATA = BASE;
  localparam logic [BITS-1:0] ADDR_CTRL = BASE + BITS'(4);
  localparam logic [BITS-1:0] ADDR_MASK = BASE + BITS'(8);
  localparam logic [BITS-1:0] ADDR_EDGE = BASE + BITS'(12);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [IN_WIDTH-1:0] samp;
  logic [IN_WIDTH-1:0] stable;
  logic [CNT_W-1:0]    cnt [IN_WIDTH];
  logic [IN_WIDTH-1:0] mask;
  logic [IN_WIDTH-1:0] edge_q;
  logic                ready;
  logic                overrun;
  logic                ie;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic wr_ctrl, wr_mask, wr_edge, rd_data, rd_any;

  assign wr_ctrl = we && (memAddr == ADDR_CTRL);
  assign wr_mask = we && (memAddr == ADDR_MASK);
  assign wr_edge = we && (memAddr == ADDR_EDGE);
  assign rd_any  = re && !we;
  assign rd_data = rd_any && (memAddr == ADDR_DATA);

  // Only the low data bits are meaningful; fold the rest away for lint.
  logic unused_bus;
  assign unused_bus = &{1'b0, dataBusIn};

  // ---------------------------------------------------------------------------
  // Optional input synchroniser
  // ---------------------------------------------------------------------------
  logic [IN_WIDTH-1:0] samp_src;

`ifdef INPUT_SYNC_EN
  logic [IN_WIDTH-1:0] sync1, sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in;
      sync2 <= sync1;
    end
  end

  assign samp_src = sync2;
`else
  assign samp_src = in;
`endif

  // ---------------------------------------------------------------------------
  // Debounce next-state
  // ---------------------------------------------------------------------------
  logic [IN_WIDTH-1:0] stable_nxt;
  logic [CNT_W-1:0]    cnt_nxt [IN_WIDTH];

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves a value held and no latch is inferred.
  always_comb begin
    stable_nxt = stable;
    cnt_nxt    = cnt;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (samp[i] == stable[i]) begin
        // Agreement (including a glitch back) restarts the count.
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        stable_nxt[i] = samp[i];
        cnt_nxt[i]    = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Change events and flag next-state
  // ---------------------------------------------------------------------------
  logic [IN_WIDTH-1:0] chg;
  logic                evt;
  logic [IN_WIDTH-1:0] edge_nxt;
  logic                ready_nxt;
  logic                overrun_nxt;

  assign chg = (stable_nxt ^ stable) & mask;
  assign evt = |chg;

  always_comb begin
    edge_nxt    = edge_q;
    ready_nxt   = ready;
    overrun_nxt = overrun;

    // Clears are applied first so that a simultaneous set wins.
    if (wr_edge) edge_nxt = edge_q & ~dataBusIn[IN_WIDTH-1:0];
    edge_nxt = edge_nxt | chg;

    if (rd_data) ready_nxt = 1'b0;
    if (evt)     ready_nxt = 1'b1;

    if (wr_ctrl && !dataBusIn[2]) overrun_nxt = 1'b0;
    // A DATA read in the same cycle consumes the earlier change, so no overrun.
    if (evt && ready && !rd_data) overrun_nxt = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp    <= '0;
      stable  <= '0;
      // NOTE: the counter array is a handful of flops, not RAM, so it is
      // reset explicitly; a mid-count reset must abandon the count.
      for (int i = 0; i < IN_WIDTH; i++) cnt[i] <= '0;
      mask    <= MASK_RESET;
      edge_q  <= '0;
      ready   <= 1'b0;
      overrun <= 1'b0;
      ie      <= 1'b0;
    end else begin
      samp    <= samp_src;
      stable  <= stable_nxt;
      for (int i = 0; i < IN_WIDTH; i++) cnt[i] <= cnt_nxt[i];
      edge_q  <= edge_nxt;
      ready   <= ready_nxt;
      overrun <= overrun_nxt;
      if (wr_mask) mask <= dataBusIn[IN_WIDTH-1:0];
      if (wr_ctrl) ie   <= dataBusIn[8];
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux and interrupt
  // ---------------------------------------------------------------------------
  always_comb begin
    dataBusOut = '0;
    if (rd_any) begin
      case (memAddr)
        ADDR_DATA: dataBusOut = BITS'(stable);
        ADDR_CTRL: dataBusOut = BITS'({ie, 5'b0, overrun, 1'b0, ready});
        ADDR_MASK: dataBusOut = BITS'(mask);
        ADDR_EDGE: dataBusOut = BITS'(edge_q);
        default:   dataBusOut = '0;
      endcase
    end
  end

  assign irq = ie & ready;

endmodule

// File: tb/tb_mmio_input_bank.sv
// -----------------------------------------------------------------------------
// tb_mmio_input_bank
//
// Directed bench for mmio_input_bank with DEBOUNCE_TIME=4 and IN_WIDTH=10.
// Inputs change 1 time unit after a rising edge; register peeks are taken
// mid-cycle with re pulsed so that no peek spans a clock edge.
// -----------------------------------------------------------------------------
module tb_mmio_input_bank;

  localparam int          IN_WIDTH = 10;
  localparam int          BITS     = 32;
  localparam logic [31:0] BASE     = 32'hF0000010;
  localparam logic [31:0] A_DATA   = BASE;
  localparam logic [31:0] A_CTRL   = BASE + 32'd4;
  localparam logic [31:0] A_MASK   = BASE + 32'd8;
  localparam logic [31:0] A_EDGE   = BASE + 32'd12;

  logic                clk = 1'b0;
  logic                reset;
  logic                we, re;
  logic [BITS-1:0]     memAddr, dataBusIn;
  logic [IN_WIDTH-1:0] in;
  logic [BITS-1:0]     dataBusOut;
  logic                irq;

  int errors = 0;
  int checks = 0;

  mmio_input_bank #(
    .IN_WIDTH     (IN_WIDTH),
    .BITS         (BITS),
    .BASE         (BASE),
    .DEBOUNCE_TIME(4),
    .MASK_RESET   (10'h3FF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .re        (re),
    .memAddr   (memAddr),
    .dataBusIn (dataBusIn),
    .in        (in),
    .dataBusOut(dataBusOut),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance n rising edges, landing 1 unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Mid-cycle combinational read with no side effect (no edge while re=1).
  task automatic peek(input logic [31:0] addr, output logic [31:0] d);
    memAddr = addr;
    re      = 1'b1;
    #1;
    d  = dataBusOut;
    re = 1'b0;
  endtask

  // Read that spans one rising edge, so read side effects take place.
  task automatic bus_read(input logic [31:0] addr, output logic [31:0] d);
    memAddr = addr;
    re      = 1'b1;
    #1;
    d = dataBusOut;
    @(posedge clk);
    #1;
    re = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] d);
    memAddr   = addr;
    dataBusIn = d;
    we        = 1'b1;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  // Drive a level, let it debounce, then clear all flags.
  task automatic settle(input logic [IN_WIDTH-1:0] v);
    logic [31:0] d;
    in = v;
    tick(7);
    bus_read(A_DATA, d);
    bus_write(A_EDGE, 32'h3FF);
    bus_write(A_CTRL, 32'h0);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b1; we = 1'b0; re = 1'b0;
    memAddr = '0; dataBusIn = '0; in = 10'h3FF;
    #2;
    peek(A_DATA, d);
    if (d !== 32'h0) begin $display("FAIL rst_data got=%h exp=%h", d, 32'h0); errors++; end
    checks++;
    peek(A_MASK, d);
    if (d !== 32'h3FF) begin $display("FAIL rst_mask got=%h exp=%h", d, 32'h3FF); errors++; end
    checks++;
    if (irq !== 1'b0) begin $display("FAIL rst_irq got=%b exp=0", irq); errors++; end
    checks++;
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b0;
    // Edges 0..4: level not yet accepted.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      peek(A_DATA, d);
      if (d !== 32'h0) begin $display("FAIL deb_early edge=%0d got=%h exp=%h", i, d, 32'h0); errors++; end
      checks++;
    end
    tick(1);
    peek(A_DATA, d);
    if (d !== 32'h3FF) begin $display("FAIL deb_data got=%h exp=%h", d, 32'h3FF); errors++; end
    checks++;
    peek(A_CTRL, d);
    if (d !== 32'h001) begin $display("FAIL deb_ctrl got=%h exp=%h", d, 32'h001); errors++; end
    checks++;
    peek(A_EDGE, d);
    if (d !== 32'h3FF) begin $display("FAIL deb_edge got=%h exp=%h", d, 32'h3FF); errors++; end
    checks++;
    if (irq !== 1'b0) begin $display("FAIL deb_irq got=%b exp=0", irq); errors++; end
    checks++;
    peek(BASE + 32'd16, d);
    if (d !== 32'h0) begin $display("FAIL unmapped got=%h exp=%h", d, 32'h0); errors++; end
    checks++;
    if (dataBusOut !== 32'h0) begin $display("FAIL idle_bus got=%h exp=%h", dataBusOut, 32'h0); errors++; end
    checks++;
    settle(10'h000);
  endtask

  task automatic test_glitch;
    logic [31:0] d;
    in = 10'h001;
    tick(3);
    in = 10'h000;
    tick(1);
    if (dut.cnt[0] !== 3'd3) begin $display("FAIL glitch_cnt_mid got=%0d exp=3", dut.cnt[0]); errors++; end
    checks++;
    tick(3);
    peek(A_DATA, d);
    if (d !== 32'h0) begin $display("FAIL glitch_data got=%h exp=%h", d, 32'h0); errors++; end
    checks++;
    peek(A_CTRL, d);
    if (d !== 32'h0) begin $display("FAIL glitch_ctrl got=%h exp=%h", d, 32'h0); errors++; end
    checks++;
    if (dut.cnt[0] !== 3'd0) begin $display("FAIL glitch_cnt got=%0d exp=0", dut.cnt[0]); errors++; end
    checks++;
  endtask

  task automatic test_overrun;
    logic [31:0] d;
    in = 10'h002;
    tick(6);
    peek(A_CTRL, d);
    if (d !== 32'h001) begin $display("FAIL ovr_first got=%h exp=%h", d, 32'h001); errors++; end
    checks++;
    in = 10'h006;
    tick(6);
    peek(A_CTRL, d);
    if (d !== 32'h005) begin $display("FAIL ovr_set got=%h exp=%h", d, 32'h005); errors++; end
    checks++;
    bus_write(A_CTRL, 32'h000);
    peek(A_CTRL, d);
    if (d !== 32'h001) begin $display("FAIL ovr_clear got=%h exp=%h", d, 32'h001); errors++; end
    checks++;
    bus_read(A_DATA, d);
    if (d !== 32'h006) begin $display("FAIL ovr_data got=%h exp=%h", d, 32'h006); errors++; end
    checks++;
    peek(A_CTRL, d);
    if (d !== 32'h000) begin $display("FAIL ovr_read got=%h exp=%h", d, 32'h000); errors++; end
    checks++;
  endtask

  task automatic test_irq_mask;
    logic [31:0] d;
    bus_write(A_EDGE, 32'h3FF);
    bus_write(A_CTRL, 32'h100);
    bus_write(A_MASK, 32'h001);
    in = 10'h00E;
    tick(6);
    peek(A_DATA, d);
    if (d !== 32'h00E) begin $display("FAIL mask_data got=%h exp=%h", d, 32'h00E); errors++; end
    checks++;
    peek(A_CTRL, d);
    if (d !== 32'h100) begin $display("FAIL mask_ctrl got=%h exp=%h", d, 32'h100); errors++; end
    checks++;
    peek(A_EDGE, d);
    if (d !== 32'h000) begin $display("FAIL mask_edge got=%h exp=%h", d, 32'h000); errors++; end
    checks++;
    if (irq !== 1'b0) begin $display("FAIL mask_irq got=%b exp=0", irq); errors++; end
    checks++;
    in = 10'h00F;
    tick(6);
    peek(A_CTRL, d);
    if (d !== 32'h101) begin $display("FAIL irq_ctrl got=%h exp=%h", d, 32'h101); errors++; end
    checks++;
    if (irq !== 1'b1) begin $display("FAIL irq_set got=%b exp=1", irq); errors++; end
    checks++;
    bus_read(A_DATA, d);
    if (d !== 32'h00F) begin $display("FAIL irq_data got=%h exp=%h", d, 32'h00F); errors++; end
    checks++;
    if (irq !== 1'b0) begin $display("FAIL irq_clear got=%b exp=0", irq); errors++; end
    checks++;
  endtask

  task automatic test_collisions;
    logic [31:0] d;
    bus_write(A_MASK, 32'h009);
    in = 10'h007;
    tick(6);
    peek(A_CTRL, d);
    if (d !== 32'h101) begin $display("FAIL col_pre got=%h exp=%h", d, 32'h101); errors++; end
    checks++;
    // Bit0 falls; the DATA read spans the accepting edge.
    in = 10'h006;
    tick(5);
    bus_read(A_DATA, d);
    if (d !== 32'h007) begin $display("FAIL col_rd_data got=%h exp=%h", d, 32'h007); errors++; end
    checks++;
    peek(A_CTRL, d);
    if (d !== 32'h101) begin $display("FAIL col_rd_ctrl got=%h exp=%h", d, 32'h101); errors++; end
    checks++;
    peek(A_DATA, d);
    if (d !== 32'h006) begin $display("FAIL col_rd_new got=%h exp=%h", d, 32'h006); errors++; end
    checks++;
    // Bit0 rises; the EDGE clear spans the accepting edge.
    in = 10'h007;
    tick(5);
    bus_write(A_EDGE, 32'h001);
    peek(A_EDGE, d);
    if (d !== 32'h009) begin $display("FAIL col_w1c got=%h exp=%h", d, 32'h009); errors++; end
    checks++;
    peek(A_CTRL, d);
    if (d !== 32'h105) begin $display("FAIL col_ovr got=%h exp=%h", d, 32'h105); errors++; end
    checks++;
    bus_write(A_EDGE, 32'h008);
    peek(A_EDGE, d);
    if (d !== 32'h001) begin $display("FAIL w1c_plain got=%h exp=%h", d, 32'h001); errors++; end
    checks++;
  endtask

  task automatic test_async_reset;
    logic [31:0] d;
    in = 10'h006;
    tick(4);
    if (dut.cnt[0] !== 3'd3) begin $display("FAIL ar_cnt_pre got=%0d exp=3", dut.cnt[0]); errors++; end
    checks++;
    if (irq !== 1'b1) begin $display("FAIL ar_irq_pre got=%b exp=1", irq); errors++; end
    checks++;
    #2;
    reset = 1'b1;
    #1;
    if (irq !== 1'b0) begin $display("FAIL ar_irq got=%b exp=0", irq); errors++; end
    checks++;
    peek(A_DATA, d);
    if (d !== 32'h0) begin $display("FAIL ar_data got=%h exp=%h", d, 32'h0); errors++; end
    checks++;
    peek(A_CTRL, d);
    if (d !== 32'h0) begin $display("FAIL ar_ctrl got=%h exp=%h", d, 32'h0); errors++; end
    checks++;
    peek(A_EDGE, d);
    if (d !== 32'h0) begin $display("FAIL ar_edge got=%h exp=%h", d, 32'h0); errors++; end
    checks++;
    peek(A_MASK, d);
    if (d !== 32'h3FF) begin $display("FAIL ar_mask got=%h exp=%h", d, 32'h3FF); errors++; end
    checks++;
    if (dut.cnt[0] !== 3'd0) begin $display("FAIL ar_cnt got=%0d exp=0", dut.cnt[0]); errors++; end
    checks++;
    reset = 1'b0;
    // Held input is re-debounced from zero: edges 0..4 still show 0.
    tick(5);
    peek(A_DATA, d);
    if (d !== 32'h0) begin $display("FAIL ar_redeb_early got=%h exp=%h", d, 32'h0); errors++; end
    checks++;
    tick(1);
    peek(A_DATA, d);
    if (d !== 32'h006) begin $display("FAIL ar_redeb got=%h exp=%h", d, 32'h006); errors++; end
    checks++;
    peek(A_CTRL, d);
    if (d !== 32'h001) begin $display("FAIL ar_redeb_ctrl got=%h exp=%h", d, 32'h001); errors++; end
    checks++;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_overrun();
    test_irq_mask();
    test_collisions();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
